// File: rtl/sync_up_down_counter_pkg.sv
// Shared constants for the loadable up/down counter.
// Optional build macro: SYNC_UP_DOWN_COUNTER_SATURATE_EN (see sync_up_down_counter.sv).
package sync_up_down_counter_pkg;

  typedef enum logic {
    MODE_DOWN = 1'b0,
    MODE_UP   = 1'b1
  } cnt_dir_e;

  localparam int CNT_WIDTH_DEFAULT = 4;

endpackage : sync_up_down_counter_pkg

// File: rtl/sync_up_down_counter_if.sv
// Control/data bundle between a counter user (master) and the counter (slave).
// Optional build macro: SYNC_UP_DOWN_COUNTER_SATURATE_EN (see sync_up_down_counter.sv).
interface sync_up_down_counter_if
  import sync_up_down_counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEFAULT
);

   logic             load;
   logic             mode;
   logic             en;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             tc;

   modport master (
      output load, mode, en, din,
      input  dout, tc
   );

   modport slave (
      input  load, mode, en, din,
      output dout, tc
   );

endinterface : sync_up_down_counter_if

// File: rtl/sync_up_down_counter.sv
// Loadable up/down binary counter with async active-low reset and terminal-count flag.
// Define SYNC_UP_DOWN_COUNTER_SATURATE_EN to make counting stop at the limits instead of wrapping.
module sync_up_down_counter
  import sync_up_down_counter_pkg::*;
#(
   parameter int WIDTH = CNT_WIDTH_DEFAULT
) (
   input  logic                   clock,
   input  logic                   rst,
   sync_up_down_counter_if.slave  bus
);

   localparam logic [WIDTH-1:0] ALL_ONES = '1;
   localparam logic [WIDTH-1:0] ZERO     = '0;
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] r_dout;
   logic [WIDTH-1:0] w_next;
   logic             w_up;

   // Load wins over counting; din is only looked at when load is set.
   function automatic logic [WIDTH-1:0] next_val(
      input logic [WIDTH-1:0] cur,
      input logic             ld,
      input logic             cnt_en,
      input logic             up,
      input logic [WIDTH-1:0] d
   );
      logic [WIDTH-1:0] nv;
      nv = cur;
      if (ld) begin
         nv = d;
      end else if (cnt_en) begin
`ifdef SYNC_UP_DOWN_COUNTER_SATURATE_EN
         if (up) nv = (cur == ALL_ONES) ? cur : cur + ONE;
         else    nv = (cur == ZERO)     ? cur : cur - ONE;
`else
         nv = up ? cur + ONE : cur - ONE;
`endif
      end
      return nv;
   endfunction

   assign w_up   = (bus.mode == MODE_UP);
   assign w_next = next_val(r_dout, bus.load, bus.en, w_up, bus.din);

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) r_dout <= ZERO;
      else      r_dout <= w_next;
   end

   assign bus.dout = r_dout;
   assign bus.tc   = w_up ? (r_dout == ALL_ONES) : (r_dout == ZERO);

endmodule : sync_up_down_counter

// File: tb/tb_sync_up_down_counter.sv
// Self-checking bench for sync_up_down_counter: directed vector table, async-reset sequence, random run.
// Expectations follow SYNC_UP_DOWN_COUNTER_SATURATE_EN when it is defined for the build.
module tb_sync_up_down_counter;
  import sync_up_down_counter_pkg::*;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;
`ifdef SYNC_UP_DOWN_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  typedef struct {
    bit ld;
    bit en;
    bit md;
    int din;
    int exp_dout;
    int exp_tc;
  } vec_t;

  logic clock;
  logic rst;
  int   n_chk;
  int   n_fail;
  int   cur;
  vec_t vecs[$];

  sync_up_down_counter_if #(.WIDTH(W)) bus ();

  sync_up_down_counter #(.WIDTH(W)) dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input int exp);
    n_chk++;
    if ($isunknown(act) || int'(act) != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_next(input int c, input bit ld, input bit en, input bit md, input int d);
    if (ld) return d;
    if (!en) return c;
    if (md) begin
      if (SAT && c == MAXV) return c;
      return (c + 1) % (MAXV + 1);
    end
    if (SAT && c == 0) return 0;
    return (c + MAXV) % (MAXV + 1);
  endfunction

  function automatic int model_tc(input int c, input bit md);
    return md ? int'(c == MAXV) : int'(c == 0);
  endfunction

  function automatic void add(input bit ld, input bit en, input bit md, input int din,
                              input int exp_dout, input int exp_tc);
    vec_t v;
    v.ld = ld; v.en = en; v.md = md; v.din = din;
    v.exp_dout = exp_dout; v.exp_tc = exp_tc;
    vecs.push_back(v);
  endfunction

  task automatic drive(input bit ld, input bit en, input bit md, input int din);
    bus.load = ld;
    bus.en   = en;
    bus.mode = md;
    bus.din  = W'(din);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    drive(0, 0, 1, 0);

    // Load 6, then ten increments crossing the top
    add(1, 0, 1, 6, 6, 0);
    for (int v = 7; v <= 15; v++) add(0, 1, 1, 0, v, (v == 15) ? 1 : 0);
    add(0, 1, 1, 0, SAT ? 15 : 0, SAT ? 1 : 0);
    add(0, 1, 1, 0, SAT ? 15 : 1, SAT ? 1 : 0);
    // Load 2, count down through zero
    add(1, 0, 0, 2, 2, 0);
    add(0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, SAT ? 0 : 15, SAT ? 1 : 0);
    add(0, 1, 0, 0, SAT ? 0 : 14, SAT ? 1 : 0);
    // Load beats count enable
    add(1, 0, 1, 3, 3, 0);
    add(1, 1, 1, 10, 10, 0);
    // Hold at 7 with mode toggling, then hold at 0 where tc follows mode
    add(1, 0, 1, 7, 7, 0);
    for (int i = 0; i < 5; i++) add(0, 0, i % 2, 12, 7, 0);
    add(1, 0, 0, 0, 0, 1);
    add(0, 0, 1, 5, 0, 0);
    add(0, 0, 0, 5, 0, 1);
    // Limits: load 14 and count up, load 1 and count down
    add(1, 0, 1, 14, 14, 0);
    add(0, 1, 1, 0, 15, 1);
    add(0, 1, 1, 0, SAT ? 15 : 0, SAT ? 1 : 0);
    add(0, 1, 1, 0, SAT ? 15 : 1, SAT ? 1 : 0);
    add(1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, SAT ? 0 : 15, SAT ? 1 : 0);
    add(0, 1, 0, 0, SAT ? 0 : 14, SAT ? 1 : 0);

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("reset_dout", bus.dout, 0);
    chk("reset_tc_up", bus.tc, 0);
    bus.mode = 1'b0;
    #1;
    chk("reset_tc_down", bus.tc, 1);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].ld, vecs[i].en, vecs[i].md, vecs[i].din);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_dout", i), bus.dout, vecs[i].exp_dout);
      chk($sformatf("vec%0d_tc", i), bus.tc, vecs[i].exp_tc);
    end

    // Async reset mid-count at 9: clears before any edge
    drive(1, 0, 1, 9);
    @(posedge clock);
    #1;
    chk("pre_rst_dout", bus.dout, 9);
    drive(0, 1, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_dout", bus.dout, 0);
    chk("async_rst_tc_down", bus.tc, 1);
    bus.mode = 1'b1;
    #1;
    chk("async_rst_tc_up", bus.tc, 0);
    drive(1, 1, 1, 13);
    @(posedge clock);
    #1;
    chk("rst_held_dout", bus.dout, 0);
    drive(0, 1, 1, 0);
    #2;
    rst = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_dout", bus.dout, 1);

    // Random run against the arithmetic model, with occasional async resets
    cur = 1;
    for (int i = 0; i < 400; i++) begin
      bit ld, en, md, do_rst;
      int d;
      ld     = ($urandom_range(0, 7) == 0);
      en     = ($urandom_range(0, 3) != 0);
      md     = $urandom_range(0, 1);
      d      = $urandom_range(0, MAXV);
      do_rst = ($urandom_range(0, 49) == 0);
      drive(ld, en, md, d);
      if (do_rst) begin
        #3;
        rst = 1'b0;
        #1;
        chk("rand_rst_dout", bus.dout, 0);
        chk("rand_rst_tc", bus.tc, md ? 0 : 1);
        #1;
        rst = 1'b1;
        cur = 0;
      end
      cur = model_next(cur, ld, en, md, d);
      @(posedge clock);
      #1;
      chk($sformatf("rand%0d_dout", i), bus.dout, cur);
      chk($sformatf("rand%0d_tc", i), bus.tc, model_tc(cur, md));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_sync_up_down_counter

// File: doc/sync_up_down_counter.md
Name: sync_up_down_counter

Overview:
- Synchronous, loadable, up/down binary counter with an active-low asynchronous reset.
- The `mode` input selects the count direction each cycle; `load` presets the counter from `din`.
- Serves as a general-purpose counter/sequencer leaf block. It provides a terminal-count flag for cascading or wrap detection.

Parameters:
- WIDTH, 4, counter and data width in bits (≥1).

Ports:
- clock  input  1  rising-edge clock; the only clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- load  input  1  synchronous parallel-load strobe, active-high.
- mode  input  1  count direction: 1 = up, 0 = down.
- en  input  1  count enable, active-high; tie to 1 for free-running counting.
- din  input  WIDTH  parallel load value.
- dout  output  WIDTH  registered counter value.
- tc  output  1  terminal count, combinational from `dout` and `mode`.

Behaviour:
- Reset:
  - `rst` low forces `dout` = 0 immediately, without waiting for a clock edge.
  - `dout` holds 0 while `rst` stays low.
  - Release is synchronous-safe: the first update occurs on the first rising edge after `rst` goes high.
- Update order on each rising edge when `rst` is high:
  1. If `load` = 1: `dout` <= `din`. `load` takes priority over `en` and `mode`.
  2. Else if `en` = 1 and `mode` = 1: `dout` <= `dout` + 1 (mod 2^WIDTH).
  3. Else if `en` = 1 and `mode` = 0: `dout` <= `dout` − 1 (mod 2^WIDTH).
  4. Else: `dout` holds.
- Latency: one cycle from a sampled `load`/`en` to the new `dout`; `dout` is fully registered.
- Wrap-around:
  - Up from 2^WIDTH−1 gives 0.
  - Down from 0 gives 2^WIDTH−1.
  - Arithmetic is unsigned and truncated to WIDTH bits.
- `tc` (combinational, no cycle delay):
  - = 1 when `mode` = 1 and `dout` = all-ones.
  - = 1 when `mode` = 0 and `dout` = 0.
  - = 0 otherwise, and 0 while `rst` is low in up mode.
- Simultaneous events:
  - `rst` low overrides everything.
  - `load` = 1 with `en` = 1 loads `din` and does not count on that cycle.
  - A `mode` change takes effect at the next edge; no extra delay is applied.
- Reset mid-operation aborts counting at once. After release, counting resumes from 0.
- X/unknown handling:
  - Inputs are treated as don't-care only while `rst` is low.
  - Implementation must not propagate X from `din` unless `load` = 1.

Optional Feature:
- Macro: SYNC_UP_DOWN_COUNTER_SATURATE_EN.
- Defined: counting saturates instead of wrapping.
  - Up at all-ones holds all-ones.
  - Down at 0 holds 0.
  - `tc` behaviour is unchanged; it is asserted while the counter is held at the limit.
  - `load` is still honoured.
- Undefined: modular wrap-around as specified above.

Decomposition:
- Package `sync_up_down_counter_pkg`:
  - Direction constants MODE_UP = 1'b1 and MODE_DOWN = 1'b0, or an equivalent 1-bit enum `cnt_dir_e`.
  - Default width constant CNT_WIDTH_DEFAULT = 4.
- No sub-module is required. Next-value logic (load/inc/dec/saturate mux) may be a function inside the package; keep it a single flat module.

Test Plan:
- Reset: `rst` = 0 mid-count at `dout` = 9 → `dout` = 0 asynchronously before the next edge. `tc` = 1 if `mode` = 0, 0 if `mode` = 1.
- Load, then count up: `load` = 1, `din` = 4'b0110 for one edge, then `load` = 0, `mode` = 1, `en` = 1 → `dout` = 6, then 7, 8, …, 15, 0, 1 (wrap after 10 increments, i.e. value 0 on the 10th). `tc` = 1 only while `dout` = 15.
- Count down through zero: from `dout` = 2, `mode` = 0 → 1, 0, 15, 14. `tc` = 1 only while `dout` = 0.
- Load priority: `load` = 1, `en` = 1, `mode` = 1, `din` = 4'hA at `dout` = 3 → `dout` = 4'hA (not 4).
- Hold: `en` = 0 for 5 cycles at `dout` = 7 → `dout` stays 7. `mode` toggling during the hold changes only `tc`.
- Saturate build (SYNC_UP_DOWN_COUNTER_SATURATE_EN): load 14, count up 3 edges → 15, 15, 15. Load 1, count down 3 edges → 0, 0, 0.
